// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with OUT/DIR/IN registers, atomic
// set/clear/toggle aliases, a 2-flop input synchroniser and an optional
// rising-edge interrupt block.
// Build option: define GPIO_BANK_IRQ_EN to include edge detection, the
// IRQ_EN (6) and IRQ_STAT (7) registers and the irq output. Without it,
// irq is tied low and addresses 6/7 read 0 and ignore writes.
module gpio_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_SET      = 3'd3;
    localparam logic [2:0] ADDR_CLR      = 3'd4;
    localparam logic [2:0] ADDR_TGL      = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

    logic [WIDTH-1:0] out_reg,   out_next;
    logic [WIDTH-1:0] dir_reg,   dir_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] sync3_reg;
    logic [WIDTH-1:0] irq_en_reg,   irq_en_next;
    logic [WIDTH-1:0] irq_stat_reg, irq_stat_next;
    logic             irq_reg;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
`endif

    // Output register update: direct write plus set/clear/toggle aliases.
    always_comb begin
        out_next = out_reg;
        dir_next = dir_reg;
        if (we) begin
            case (addr)
                ADDR_OUT: out_next = wdata;
                ADDR_DIR: dir_next = wdata;
                ADDR_SET: out_next = out_reg | wdata;
                ADDR_CLR: out_next = out_reg & ~wdata;
                ADDR_TGL: out_next = out_reg ^ wdata;
                default:  out_next = out_reg;
            endcase
        end
    end

    // Read mux samples register values from before any same-cycle write.
    always_comb begin
        rdata_next = '0;
        case (addr)
            ADDR_OUT: rdata_next = out_reg;
            ADDR_DIR: rdata_next = dir_reg;
            ADDR_IN:  rdata_next = sync2_reg;
            ADDR_SET: rdata_next = out_reg;
            ADDR_CLR: rdata_next = out_reg;
            ADDR_TGL: rdata_next = out_reg;
`ifdef GPIO_BANK_IRQ_EN
            ADDR_IRQ_EN:   rdata_next = irq_en_reg;
            ADDR_IRQ_STAT: rdata_next = irq_stat_reg;
`endif
            default:  rdata_next = '0;
        endcase
    end

    // Core registers and the two-stage input synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= '0;
            dir_reg   <= '0;
            rdata_reg <= '0;
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            rdata_reg <= rdata_next;
            sync1_reg <= gpio_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    assign rise = sync2_reg & ~sync3_reg;
    assign w1c  = (we && (addr == ADDR_IRQ_STAT)) ? wdata : '0;

    // Interrupt enable register write.
    always_comb begin
        irq_en_next = irq_en_reg;
        if (we && (addr == ADDR_IRQ_EN)) begin
            irq_en_next = wdata;
        end
    end

    // Per-bit sticky status: a set event outranks a same-cycle clear.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stat
            assign irq_stat_next[gi] = (rise[gi] & irq_en_reg[gi]) |
                                       (irq_stat_reg[gi] & ~w1c[gi]);
        end
    endgenerate

    // Edge-history flop, interrupt registers and the registered irq level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync3_reg    <= '0;
            irq_en_reg   <= '0;
            irq_stat_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            sync3_reg    <= sync2_reg;
            irq_en_reg   <= irq_en_next;
            irq_stat_reg <= irq_stat_next;
            irq_reg      <= |(irq_stat_reg & irq_en_reg);
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    assign rdata    = rdata_reg;
    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed plus randomized stimulus for gpio_bank, checked
// every cycle against a queue-based behavioural model. Honours
// GPIO_BANK_IRQ_EN the same way as the design.
module tb_gpio_bank;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we = 1'b0;
    logic [2:0]   addr = 3'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [W-1:0] m_out = '0;
    logic [W-1:0] m_dir = '0;
    logic [W-1:0] m_en = '0;
    logic [W-1:0] m_stat = '0;
    logic [W-1:0] m_rdata = '0;
    logic         m_irq = 1'b0;
    // hist[0] = newest sampled pin value; IN shows the value sampled two
    // edges back, and the value three edges back marks the previous IN.
    logic [W-1:0] hist[$];

    gpio_bank #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] in_now;
        logic [W-1:0] in_old;
        logic [W-1:0] rising;
        logic [W-1:0] clr_mask;
        logic [W-1:0] new_stat;
        if (rst) begin
            m_out = '0; m_dir = '0; m_en = '0; m_stat = '0;
            m_rdata = '0; m_irq = 1'b0;
            hist = '{8'h00, 8'h00, 8'h00};
        end else begin
            in_now = hist[1];
            in_old = hist[2];
            case (addr)
                3'd0, 3'd3, 3'd4, 3'd5: m_rdata = m_out;
                3'd1: m_rdata = m_dir;
                3'd2: m_rdata = in_now;
`ifdef GPIO_BANK_IRQ_EN
                3'd6: m_rdata = m_en;
                3'd7: m_rdata = m_stat;
`endif
                default: m_rdata = '0;
            endcase
`ifdef GPIO_BANK_IRQ_EN
            m_irq = (m_stat & m_en) != 0;
            rising = in_now & ~in_old;
            clr_mask = (we && addr == 3'd7) ? wdata : '0;
            new_stat = (m_stat & ~clr_mask) | (rising & m_en);
            m_stat = new_stat;
            if (we && addr == 3'd6) m_en = wdata;
`else
            m_irq = 1'b0;
`endif
            if (we) begin
                case (addr)
                    3'd0: m_out = wdata;
                    3'd1: m_dir = wdata;
                    3'd3: m_out = m_out | wdata;
                    3'd4: m_out = m_out & ~wdata;
                    3'd5: m_out = m_out ^ wdata;
                    default: ;
                endcase
            end
            hist.push_front(gpio_in);
            void'(hist.pop_back());
        end
    endtask

    // One clock: advance the model at the edge, compare outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oe", gpio_oe, m_dir);
        chk("rdata", rdata, m_rdata);
        chk("irq", irq, m_irq);
    endtask

    task automatic drive(input logic w, input logic [2:0] a, input logic [W-1:0] d);
        we = w; addr = a; wdata = d;
    endtask

    initial begin
        hist = '{8'h00, 8'h00, 8'h00};

        // Reset state
        rst = 1'b1;
        drive(1'b1, 3'd0, 8'h77);
        tick(); tick();
        chk("reset_out", gpio_out, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        rst = 1'b0;

        // OUT / DIR write and read-back
        drive(1'b1, 3'd0, 8'hA5); tick();
        drive(1'b1, 3'd1, 8'hFF); tick();
        chk("out_a5", gpio_out, 8'hA5);
        chk("oe_ff", gpio_oe, 8'hFF);
        drive(1'b0, 3'd0, 8'h00); tick();
        chk("read_out", rdata, 8'hA5);

        // Set / clear / toggle aliases
        drive(1'b1, 3'd3, 8'h0A); tick();
        chk("set", gpio_out, 8'hAF);
        drive(1'b1, 3'd4, 8'h81); tick();
        chk("clr", gpio_out, 8'h2E);
        drive(1'b1, 3'd5, 8'hFF); tick();
        chk("tgl", gpio_out, 8'hD1);
        drive(1'b0, 3'd4, 8'h00); tick();
        chk("read_clr_alias", rdata, 8'hD1);

        // DIR=0 does not affect OUT
        drive(1'b1, 3'd1, 8'h00); tick();
        drive(1'b0, 3'd0, 8'h00); tick();
        chk("out_dir0", gpio_out, 8'hD1);

        // Input synchroniser latency and read-only IN
        gpio_in = 8'h3C;
        drive(1'b0, 3'd2, 8'h00);
        tick(); tick();
        chk("in_latency", rdata, 8'h00);
        tick();
        chk("in_value", rdata, 8'h3C);
        drive(1'b1, 3'd2, 8'hFF); tick();
        drive(1'b0, 3'd2, 8'h00); tick();
        chk("in_ro", rdata, 8'h3C);
        chk("in_ro_out", gpio_out, 8'hD1);

        // Rising-edge interrupt and W1C
        gpio_in = 8'h00;
        tick(); tick(); tick();
        drive(1'b1, 3'd6, 8'h04); tick();
        drive(1'b0, 3'd7, 8'h00);
        gpio_in = 8'h04;
        for (int i = 0; i < 5; i++) tick();
`ifdef GPIO_BANK_IRQ_EN
        chk("stat_set", rdata, 8'h04);
        chk("irq_set", irq, 1'b1);
`endif
        drive(1'b1, 3'd7, 8'h04); tick();
        drive(1'b0, 3'd7, 8'h00); tick();
        chk("irq_cleared", irq, 1'b0);

        // Set beats same-cycle W1C
        gpio_in = 8'h00;
        tick(); tick(); tick();
        gpio_in = 8'h04;
        tick(); tick();
        drive(1'b1, 3'd7, 8'h04); tick();
        drive(1'b0, 3'd7, 8'h00); tick();
`ifdef GPIO_BANK_IRQ_EN
        chk("set_wins", rdata, 8'h04);
`endif
        // Masking via IRQ_EN keeps status
        drive(1'b1, 3'd6, 8'h00); tick();
        drive(1'b0, 3'd7, 8'h00); tick(); tick();
        chk("irq_masked", irq, 1'b0);
`ifdef GPIO_BANK_IRQ_EN
        chk("stat_kept", rdata, 8'h04);
`endif

        // Reset mid-operation with a concurrent write
        gpio_in = 8'h00;
        drive(1'b1, 3'd0, 8'hFF); tick();
        drive(1'b1, 3'd6, 8'h01); tick();
        gpio_in = 8'h01;
        drive(1'b0, 3'd7, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        drive(1'b1, 3'd0, 8'h55); tick();
        chk("rst_out", gpio_out, 8'h00);
        chk("rst_oe", gpio_oe, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_irq", irq, 1'b0);

        // Pin held high through reset must not raise status
        rst = 1'b0;
        drive(1'b0, 3'd7, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("no_stat_after_rst", rdata, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            we = $urandom_range(0, 1);
            addr = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
